// File: rtl/keypad_event_queue.sv
// keypad_event_queue
// Converts the debounced keypad scanner's key code into discrete key events
// (press, rollover and optional auto-repeat) and queues them in a small FIFO
// that the CPU drains through three word-aligned bus registers.
//
// Ports:
//   clk       system clock, all logic on posedge
//   resetn    asynchronous active-low reset
//   key_code  scanner key code, 0 = no key, ASCII in [7:0]
//   addr      byte address, [3:2] selects DATA / STATUS / CTRL / reserved
//   rd_en     bus read strobe (one cycle per access)
//   wr_en     bus write strobe (one cycle per access), wins over rd_en
//   wdata     bus write data
//   rdata     registered read data, held until the next read
//   irq       level interrupt: irq_en and queue non-empty, registered
module keypad_event_queue #(
   parameter int unsigned DEPTH        = 8,
   parameter logic [23:0] REPEAT_DELAY = 24'd500000,
   parameter logic [23:0] REPEAT_RATE  = 24'd100000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] key_code,
   input  logic [3:0]  addr,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;
   localparam logic [23:0] DELAY_LAST = REPEAT_DELAY - 24'd1;
   localparam logic [23:0] RATE_LAST  = REPEAT_RATE - 24'd1;

   localparam logic [1:0] SEL_DATA   = 2'd0;
   localparam logic [1:0] SEL_STATUS = 2'd1;
   localparam logic [1:0] SEL_CTRL   = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_HELD, S_REPEAT} state_t;

   state_t            r_state;
   logic [31:0]       r_key;
   logic [7:0]        r_held;
   logic [23:0]       r_hold_cnt;
   logic [7:0]        r_mem [DEPTH];
   logic [AW-1:0]     r_wp;
   logic [AW-1:0]     r_rp;
   logic [CNT_W-1:0]  r_count;
   logic              r_overflow;
   logic              r_irq_en;
   logic              r_repeat_en;

   state_t            w_nstate;
   logic [7:0]        w_nheld;
   logic [23:0]       w_ncnt;
   logic              w_push;
   logic              w_key_nz;
   logic [1:0]        w_sel;
   logic              w_wr;
   logic              w_rd;
   logic              w_empty;
   logic              w_full;
   logic              w_flush;
   logic              w_pop;
   logic              w_do_push;
   logic              w_ovf_set;
   logic              w_ovf_clr;
   logic [31:0]       w_rdata;
   logic              w_unused;

   assign w_key_nz = |r_key;
   assign w_sel    = addr[3:2];
   assign w_wr     = wr_en;
   assign w_rd     = rd_en & ~wr_en;
   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == CNT_W'(DEPTH));
   assign w_unused = ^{addr[1:0], wdata[31:9], wdata[7:3]};

   // Press decoding runs on the registered key code. A rollover from REPEAT
   // goes back to HELD so the new key waits the full initial delay.
   always_comb begin
      w_nstate = r_state;
      w_nheld  = r_held;
      w_ncnt   = r_hold_cnt;
      w_push   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_key_nz) begin
               w_push   = 1'b1;
               w_nheld  = r_key[7:0];
               w_ncnt   = '0;
               w_nstate = S_HELD;
            end
         end
         default: begin
            if (!w_key_nz) begin
               w_nstate = S_IDLE;
               w_ncnt   = '0;
            end else if (r_key[7:0] != r_held) begin
               w_push   = 1'b1;
               w_nheld  = r_key[7:0];
               w_ncnt   = '0;
               w_nstate = S_HELD;
            end else if (!r_repeat_en) begin
               if (r_state == S_REPEAT) begin
                  w_nstate = S_HELD;
                  w_ncnt   = '0;
               end
            end else if (r_state == S_HELD) begin
               if (r_hold_cnt == DELAY_LAST) begin
                  w_push   = 1'b1;
                  w_ncnt   = '0;
                  w_nstate = S_REPEAT;
               end else begin
                  w_ncnt = r_hold_cnt + 24'd1;
               end
            end else begin
               if (r_hold_cnt == RATE_LAST) begin
                  w_push = 1'b1;
                  w_ncnt = '0;
               end else begin
                  w_ncnt = r_hold_cnt + 24'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_key      <= '0;
         r_state    <= S_IDLE;
         r_held     <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_key      <= key_code;
         r_state    <= w_nstate;
         r_held     <= w_nheld;
         r_hold_cnt <= w_ncnt;
      end
   end

   // A pop frees a slot in the same cycle, so a push into a full queue
   // alongside a pop is kept. A flush discards any push in its cycle.
   assign w_flush   = w_wr & (w_sel == SEL_CTRL) & wdata[2];
   assign w_pop     = w_rd & (w_sel == SEL_DATA) & ~w_empty;
   assign w_do_push = w_push & ~w_flush & (~w_full | w_pop);
   assign w_ovf_set = w_push & ~w_flush & w_full & ~w_pop;
   assign w_ovf_clr = w_wr & (w_sel == SEL_STATUS) & wdata[8];

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wp] <= r_held_next_code();
      end
   end

   function automatic logic [7:0] r_held_next_code();
      return w_nheld;
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wp       <= '0;
         r_rp       <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
         end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_pop)     r_rp <= r_rp + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_pop};
         end
         // Set beats clear when both happen together.
         if (w_ovf_set)      r_overflow <= 1'b1;
         else if (w_ovf_clr) r_overflow <= 1'b0;
      end
   end

   always_comb begin
      w_rdata = '0;
      case (w_sel)
         SEL_DATA:   w_rdata = w_empty ? 32'd0 : {24'd0, r_mem[r_rp]};
         SEL_STATUS: w_rdata = {8'd0, 8'(r_count), 7'd0, r_overflow, 6'd0, w_full, w_empty};
         SEL_CTRL:   w_rdata = {30'd0, r_repeat_en, r_irq_en};
         default:    w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata       <= '0;
         irq         <= 1'b0;
         r_irq_en    <= 1'b0;
         r_repeat_en <= 1'b0;
      end else begin
         if (w_rd) rdata <= w_rdata;
         if (w_wr && (w_sel == SEL_CTRL)) begin
            r_irq_en    <= wdata[0];
            r_repeat_en <= wdata[1];
         end
         irq <= r_irq_en & ~w_empty;
      end
   end

endmodule

// File: tb/tb_keypad_event_queue.sv
// tb_keypad_event_queue
// Directed bench for keypad_event_queue with short repeat timing
// (REPEAT_DELAY = 10, REPEAT_RATE = 4, DEPTH = 8).
module tb_keypad_event_queue;

   logic        clk;
   logic        resetn;
   logic [31:0] key_code;
   logic [3:0]  addr;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] rd;

   localparam logic [3:0] A_DATA   = 4'h0;
   localparam logic [3:0] A_STATUS = 4'h4;
   localparam logic [3:0] A_CTRL   = 4'h8;
   localparam logic [3:0] A_RSVD   = 4'hC;

   keypad_event_queue #(
      .DEPTH        (8),
      .REPEAT_DELAY (24'd10),
      .REPEAT_RATE  (24'd4)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .key_code (key_code),
      .addr     (addr),
      .rd_en    (rd_en),
      .wr_en    (wr_en),
      .wdata    (wdata),
      .rdata    (rdata),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      addr  = a;
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      d     = rdata;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      wr_en = 1'b1;
      tick(1);
      wr_en = 1'b0;
      wdata = '0;
   endtask

   task automatic press(input logic [31:0] k);
      key_code = k;
      tick(2);
      key_code = '0;
      tick(2);
   endtask

   initial begin
      resetn   = 1'b0;
      key_code = '0;
      addr     = '0;
      rd_en    = 1'b0;
      wr_en    = 1'b0;
      wdata    = '0;
      tick(3);
      check("reset_rdata", rdata, 32'h0);
      check("reset_irq", {31'd0, irq}, 32'h0);
      resetn = 1'b1;
      tick(1);
      bus_read(A_STATUS, rd);  check("reset_status", rd, 32'h0000_0001);
      bus_read(A_CTRL, rd);    check("reset_ctrl", rd, 32'h0);

      // single press of '5' held 20 cycles
      key_code = 32'd53;
      tick(20);
      key_code = '0;
      tick(3);
      bus_read(A_STATUS, rd);  check("p5_status", rd, 32'h0001_0000);
      bus_read(A_DATA, rd);    check("p5_data", rd, 32'h0000_0035);
      bus_read(A_STATUS, rd);  check("p5_status_empty", rd, 32'h0000_0001);
      bus_read(A_DATA, rd);    check("p5_data_empty", rd, 32'h0);
      bus_read(A_RSVD, rd);    check("rsvd_read", rd, 32'h0);

      // ten distinct presses into an 8-deep queue
      for (int i = 0; i < 10; i++) press(32'h41 + i);
      tick(2);
      bus_read(A_STATUS, rd);  check("ovf_status", rd, 32'h0008_0102);
      for (int i = 0; i < 8; i++) begin
         bus_read(A_DATA, rd);
         check($sformatf("ovf_data%0d", i), rd, 32'h41 + i);
      end
      bus_read(A_STATUS, rd);  check("ovf_drained", rd, 32'h0000_0101);
      bus_write(A_STATUS, 32'h100);
      bus_read(A_STATUS, rd);  check("ovf_cleared", rd, 32'h0000_0001);

      // auto-repeat: 'A' held 30 cycles -> press + first repeat + 4 more
      bus_write(A_CTRL, 32'h2);
      bus_read(A_CTRL, rd);    check("ctrl_repeat", rd, 32'h0000_0002);
      key_code = 32'd65;
      tick(30);
      key_code = '0;
      tick(4);
      bus_read(A_STATUS, rd);  check("rep_status", rd, 32'h0006_0000);
      for (int i = 0; i < 6; i++) begin
         bus_read(A_DATA, rd);
         check($sformatf("rep_data%0d", i), rd, 32'h41);
      end
      bus_read(A_DATA, rd);    check("rep_data_empty", rd, 32'h0);
      bus_write(A_CTRL, 32'h0);

      // rollover '1' -> '2' without release, repeat disabled
      key_code = 32'h31;
      tick(15);
      key_code = 32'h32;
      tick(15);
      key_code = '0;
      tick(3);
      bus_read(A_STATUS, rd);  check("roll_status", rd, 32'h0002_0000);
      bus_read(A_DATA, rd);    check("roll_data0", rd, 32'h31);
      bus_read(A_DATA, rd);    check("roll_data1", rd, 32'h32);
      bus_read(A_STATUS, rd);  check("roll_empty", rd, 32'h0000_0001);

      // interrupt timing
      bus_write(A_CTRL, 32'h1);
      tick(2);
      check("irq_empty", {31'd0, irq}, 32'h0);
      key_code = 32'h23;
      tick(2);
      check("irq_at_push", {31'd0, irq}, 32'h0);
      tick(1);
      check("irq_after_push", {31'd0, irq}, 32'h1);
      key_code = '0;
      bus_read(A_DATA, rd);    check("irq_data", rd, 32'h23);
      check("irq_at_pop", {31'd0, irq}, 32'h1);
      tick(1);
      check("irq_after_pop", {31'd0, irq}, 32'h0);
      tick(3);

      // full queue: push and pop in the same cycle, then flush
      for (int i = 0; i < 8; i++) press(32'h61 + i);
      tick(2);
      bus_read(A_STATUS, rd);  check("full_status", rd, 32'h0008_0002);
      key_code = 32'h7A;
      tick(1);
      bus_read(A_DATA, rd);    check("full_pop_data", rd, 32'h61);
      key_code = '0;
      tick(3);
      bus_read(A_STATUS, rd);  check("full_pushpop_status", rd, 32'h0008_0002);
      check("full_irq", {31'd0, irq}, 32'h1);
      bus_write(A_CTRL, 32'h4);
      bus_read(A_STATUS, rd);  check("flush_status", rd, 32'h0000_0001);
      check("flush_irq", {31'd0, irq}, 32'h0);
      bus_read(A_CTRL, rd);    check("flush_ctrl", rd, 32'h0);

      // reset in the middle of operation discards the queue
      press(32'h5A);
      bus_read(A_STATUS, rd);  check("pre_reset_status", rd, 32'h0001_0000);
      resetn = 1'b0;
      #1;
      check("midreset_rdata", rdata, 32'h0);
      tick(2);
      resetn = 1'b1;
      tick(1);
      bus_read(A_STATUS, rd);  check("post_reset_status", rd, 32'h0000_0001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
